// File: rtl/edugpu_host_req_bridge_pkg.sv
// Shared types and constants for the host request bridge: FSM encoding, error data, command word.
package edugpu_host_req_bridge_pkg;

  typedef enum logic [1:0] {StIdle, StRdReq, StWrReq, StResp} state_e;

  localparam logic [31:0] ErrorDataDefault = 32'hDEAD_BEEF;
  localparam int unsigned CmdWidthDefault  = 1 + 16 + 32;

  // Command word layout, MSB first: {write, addr, data}.
  function automatic int unsigned cmd_width(int unsigned addr_w, int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/edugpu_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and a combinational head read.
module edugpu_sync_fifo
  import edugpu_host_req_bridge_pkg::*;
#(
  parameter int unsigned WIDTH = CmdWidthDefault,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Power-of-two depth lets the pointers wrap on natural overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CntW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/edugpu_host_req_bridge.sv
// Host command stream to single-outstanding GPU pcie_* request bridge with
// command FIFO, in-order responses and a per-request timeout.
module edugpu_host_req_bridge
  import edugpu_host_req_bridge_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH     = 16,
  parameter int unsigned            DATA_WIDTH     = 32,
  parameter int unsigned            FIFO_DEPTH     = 4,
  parameter int unsigned            TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0]  ERROR_DATA     = DATA_WIDTH'(ErrorDataDefault)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_is_write,
  output logic                  rsp_error,
  output logic                  pcie_read_request,
  output logic [ADDR_WIDTH-1:0] pcie_read_addr,
  input  logic                  pcie_read_ready,
  input  logic [DATA_WIDTH-1:0] pcie_read_data,
  output logic                  pcie_write_request,
  output logic [ADDR_WIDTH-1:0] pcie_write_addr,
  output logic [DATA_WIDTH-1:0] pcie_write_data,
  input  logic                  pcie_write_ready,
  output logic                  busy,
  output logic [7:0]            timeout_count
);

  localparam int unsigned     CmdW     = cmd_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned     WaitW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CmdW-1:0] fifo_din, fifo_dout;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [WaitW-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_is_write_q, rsp_is_write_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [7:0]            timeout_count_q, timeout_count_d;
  logic                  is_wr, chan_ready, timeout_hit;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;
  assign fifo_din  = {cmd_write, cmd_addr, cmd_wdata};

  edugpu_sync_fifo #(
    .WIDTH (CmdW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Only the ready of the channel currently being requested is honoured.
  assign is_wr       = (state_q == StWrReq);
  assign chan_ready  = is_wr ? pcie_write_ready : pcie_read_ready;
  assign timeout_hit = (wait_cnt_q == WaitLast);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wait_cnt_d      = wait_cnt_q;
    rd_req_d        = rd_req_q;
    wr_req_d        = wr_req_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_data_d      = rsp_data_q;
    rsp_is_write_d  = rsp_is_write_q;
    rsp_error_d     = rsp_error_q;
    timeout_count_d = timeout_count_q;
    fifo_pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          addr_d     = fifo_dout[DATA_WIDTH +: ADDR_WIDTH];
          wdata_d    = fifo_dout[DATA_WIDTH-1:0];
          wait_cnt_d = '0;
          if (fifo_dout[CmdW-1]) begin
            state_d  = StWrReq;
            wr_req_d = 1'b1;
          end else begin
            state_d  = StRdReq;
            rd_req_d = 1'b1;
          end
        end
      end
      StRdReq, StWrReq: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (chan_ready || timeout_hit) begin
          state_d        = StResp;
          rd_req_d       = 1'b0;
          wr_req_d       = 1'b0;
          rsp_valid_d    = 1'b1;
          rsp_is_write_d = is_wr;
          rsp_error_d    = !chan_ready;
          if (is_wr) begin
            rsp_data_d = '0;
          end else begin
            rsp_data_d = chan_ready ? pcie_read_data : ERROR_DATA;
          end
          if (!chan_ready && (timeout_count_q != 8'hFF)) begin
            timeout_count_d = timeout_count_q + 8'd1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      wdata_q         <= '0;
      wait_cnt_q      <= '0;
      rd_req_q        <= 1'b0;
      wr_req_q        <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= '0;
      rsp_is_write_q  <= 1'b0;
      rsp_error_q     <= 1'b0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wait_cnt_q      <= wait_cnt_d;
      rd_req_q        <= rd_req_d;
      wr_req_q        <= wr_req_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_is_write_q  <= rsp_is_write_d;
      rsp_error_q     <= rsp_error_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign pcie_read_request  = rd_req_q;
  assign pcie_read_addr     = addr_q;
  assign pcie_write_request = wr_req_q;
  assign pcie_write_addr    = addr_q;
  assign pcie_write_data    = wdata_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_data           = rsp_data_q;
  assign rsp_is_write       = rsp_is_write_q;
  assign rsp_error          = rsp_error_q;
  assign timeout_count      = timeout_count_q;
  assign busy               = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_edugpu_host_req_bridge.sv
// Self-checking bench for edugpu_host_req_bridge: queue-based reference model plus directed checks.
module tb_edugpu_host_req_bridge;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 16;

  logic          clock = 1'b0, reset_n = 1'b1;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, rsp_is_write, rsp_error;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          pcie_read_request, pcie_write_request, busy;
  logic [AW-1:0] pcie_read_addr, pcie_write_addr;
  logic          pcie_read_ready = 1'b0, pcie_write_ready = 1'b0;
  logic [DW-1:0] pcie_read_data = '0, pcie_write_data;
  logic [7:0]    timeout_count;

  always #5 clock = ~clock;

  edugpu_host_req_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .ERROR_DATA     (32'hDEAD_BEEF)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_write          (cmd_write),
    .cmd_addr           (cmd_addr),
    .cmd_wdata          (cmd_wdata),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_data           (rsp_data),
    .rsp_is_write       (rsp_is_write),
    .rsp_error          (rsp_error),
    .pcie_read_request  (pcie_read_request),
    .pcie_read_addr     (pcie_read_addr),
    .pcie_read_ready    (pcie_read_ready),
    .pcie_read_data     (pcie_read_data),
    .pcie_write_request (pcie_write_request),
    .pcie_write_addr    (pcie_write_addr),
    .pcie_write_data    (pcie_write_data),
    .pcie_write_ready   (pcie_write_ready),
    .busy               (busy),
    .timeout_count      (timeout_count)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending commands, the one in flight, and a memory image.
  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            dly;   // request cycles until ready; 0 = never
  } cmd_t;

  cmd_t          mq[$];
  cmd_t          cur;
  int            phase = 0;  // 0 waiting for work, 1 requesting, 2 responding
  int            age = 0;
  int            cmd_dly = 1;
  logic [DW-1:0] mem [int];
  bit            last_push = 1'b0, started = 1'b0, hold_rsp = 1'b0;
  bit            e_cmd_ready = 1'b1, e_busy = 1'b0, e_rsp_valid = 1'b0;
  bit            e_rsp_w = 1'b0, e_rsp_err = 1'b0;
  logic [DW-1:0] e_rsp_data = '0;
  int            e_tcount = 0;
  int            dut_rsp_cnt = 0;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {16'h5A5A, a};
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      mq.delete();
      phase = 0; age = 0; last_push = 1'b0;
      e_rsp_valid = 1'b0; e_tcount = 0; e_cmd_ready = 1'b1; e_busy = 1'b0;
    end else begin
      bit   push_now;
      bit   rdy;
      cmd_t nc;
      push_now  = cmd_valid && e_cmd_ready;
      last_push = push_now;
      if (phase == 0) begin
        if (mq.size() > 0) begin
          cur = mq.pop_front(); phase = 1; age = 0;
        end
      end else if (phase == 1) begin
        rdy = cur.w ? pcie_write_ready : pcie_read_ready;
        if (rdy) begin
          phase = 2; e_rsp_valid = 1'b1; e_rsp_w = cur.w; e_rsp_err = 1'b0;
          if (cur.w) begin
            mem[int'(cur.a)] = cur.d;
            e_rsp_data = '0;
          end else begin
            e_rsp_data = mem_val(cur.a);
          end
        end else if (age == TO - 1) begin
          phase = 2; e_rsp_valid = 1'b1; e_rsp_w = cur.w; e_rsp_err = 1'b1;
          e_rsp_data = cur.w ? 32'h0 : 32'hDEAD_BEEF;
          if (e_tcount < 255) e_tcount++;
        end else begin
          age++;
        end
      end else if (rsp_ready) begin
        phase = 0; e_rsp_valid = 1'b0;
      end
      if (push_now) begin
        nc.w = cmd_write; nc.a = cmd_addr; nc.d = cmd_wdata; nc.dly = cmd_dly;
        mq.push_back(nc);
      end
      e_cmd_ready = (mq.size() < DEPTH);
      e_busy      = (mq.size() != 0) || (phase != 0);
    end
  end

  // Memory-side responder and host response acceptance, driven from the model's view.
  always @(posedge clock) begin
    #1;
    rsp_ready        = hold_rsp ? 1'b0 : ($urandom_range(0, 2) != 0);
    pcie_read_data   = $urandom;
    pcie_read_ready  = ($urandom_range(0, 7) == 0);
    pcie_write_ready = ($urandom_range(0, 7) == 0);
    if (phase == 1) begin
      bit hit;
      hit = (cur.dly != 0) && (age == cur.dly - 1);
      if (cur.w) begin
        pcie_write_ready = hit;
      end else begin
        pcie_read_ready = hit;
        if (hit) pcie_read_data = mem_val(cur.a);
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && rsp_valid && rsp_ready) dut_rsp_cnt++;
  end

  always @(negedge clock) begin
    if (started) begin
      if (!reset_n) begin
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_req", pcie_read_request, 0);
        chk("rst_wr_req", pcie_write_request, 0);
        chk("rst_tcount", timeout_count, 0);
      end else begin
        chk("cmd_ready", cmd_ready, e_cmd_ready);
        chk("busy", busy, e_busy);
        chk("rsp_valid", rsp_valid, e_rsp_valid);
        chk("timeout_count", timeout_count, e_tcount);
        chk("rd_req", pcie_read_request, (phase == 1) && !cur.w);
        chk("wr_req", pcie_write_request, (phase == 1) && cur.w);
        chk("req_exclusive", pcie_read_request & pcie_write_request, 0);
        if (phase == 1 && !cur.w) chk("rd_addr", pcie_read_addr, cur.a);
        if (phase == 1 && cur.w) begin
          chk("wr_addr", pcie_write_addr, cur.a);
          chk("wr_data", pcie_write_data, cur.d);
        end
        if (e_rsp_valid) begin
          chk("rsp_data", rsp_data, e_rsp_data);
          chk("rsp_is_write", rsp_is_write, e_rsp_w);
          chk("rsp_error", rsp_error, e_rsp_err);
        end
      end
    end
  end

  task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int dly);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_dly = dly;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock); #1;
      if (last_push) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0; cmd_wdata = $urandom;
    if (!ok) chk("send_accept_timeout", 0, 1);
  endtask

  // Finds the next request and counts the cycles it stays high.
  task automatic measure(output bit found, output int hi, output logic [AW-1:0] a,
                         output logic [DW-1:0] d, output bit was_wr);
    found = 1'b0; hi = 0; a = '0; d = '0; was_wr = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (pcie_read_request || pcie_write_request) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      was_wr = pcie_write_request;
      a      = was_wr ? pcie_write_addr : pcie_read_addr;
      d      = pcie_write_data;
      hi     = 1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clock);
        if (!(pcie_read_request || pcie_write_request)) break;
        hi++;
      end
    end
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      if (phase == 0 && mq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit            found, was_wr, got;
    int            hi, base;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    #1 reset_n = 1'b0;
    started = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_rsp_data", rsp_data, 0);
    chk("post_rst_rsp_is_write", rsp_is_write, 0);
    chk("post_rst_rsp_error", rsp_error, 0);
    chk("post_rst_rd_addr", pcie_read_addr, 0);
    chk("post_rst_wr_data", pcie_write_data, 0);

    // Single write, ready in the third request cycle.
    send(1'b1, 16'h0010, 32'h1234_5678, 3);
    measure(found, hi, a, d, was_wr);
    chk("wr_found", found, 1);
    chk("wr_channel", was_wr, 1);
    chk("wr_hold_cycles", hi, 3);
    chk("wr_addr_lit", a, 32'h0010);
    chk("wr_data_lit", d, 32'h1234_5678);
    wait_rsp(got);
    chk("wr_rsp_seen", got, 1);
    chk("wr_rsp_is_write", rsp_is_write, 1);
    chk("wr_rsp_error", rsp_error, 0);
    chk("wr_rsp_data", rsp_data, 0);
    wait_idle();

    // Single read of a preloaded word, ready after five cycles.
    mem[32'h0020] = 32'hCAFE_0001;
    send(1'b0, 16'h0020, $urandom, 5);
    measure(found, hi, a, d, was_wr);
    chk("rd_found", found, 1);
    chk("rd_channel", was_wr, 0);
    chk("rd_hold_cycles", hi, 5);
    chk("rd_addr_lit", a, 32'h0020);
    wait_rsp(got);
    chk("rd_rsp_seen", got, 1);
    chk("rd_rsp_data", rsp_data, 32'hCAFE_0001);
    chk("rd_rsp_is_write", rsp_is_write, 0);
    wait_idle();

    // FIFO fill: one read stuck in response, four queued behind it.
    hold_rsp = 1'b1;
    for (int i = 0; i < 6; i++) mem[32'h0100 + i] = 32'hF1F0_0000 + i;
    for (int i = 0; i < 5; i++) send(1'b0, AW'(16'h0100 + i), 32'h0, 1);
    repeat (4) @(negedge clock);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_rsp_valid", rsp_valid, 1);
    chk("full_first_data", rsp_data, 32'hF1F0_0000);
    base = dut_rsp_cnt;
    fork
      send(1'b0, 16'h0105, 32'h0, 1);
      begin
        repeat (3) @(posedge clock);
        #1 hold_rsp = 1'b0;
      end
    join
    wait_idle();
    repeat (2) @(negedge clock);
    chk("drain_count", dut_rsp_cnt - base, 6);

    // Read timeout, then a normal read.
    send(1'b0, 16'h0030, 32'h0, 0);
    measure(found, hi, a, d, was_wr);
    chk("to_hold_cycles", hi, 16);
    wait_rsp(got);
    chk("to_rsp_error", rsp_error, 1);
    chk("to_rsp_data", rsp_data, 32'hDEAD_BEEF);
    chk("to_tcount", timeout_count, 1);
    wait_idle();
    mem[32'h0030] = 32'h3030_3030;
    send(1'b0, 16'h0030, 32'h0, 2);
    measure(found, hi, a, d, was_wr);
    chk("after_to_hold", hi, 2);
    wait_rsp(got);
    chk("after_to_error", rsp_error, 0);
    chk("after_to_data", rsp_data, 32'h3030_3030);
    wait_idle();

    // Ready in the last allowed cycle beats the timeout.
    mem[32'h0040] = 32'h4040_0016;
    send(1'b0, 16'h0040, 32'h0, 16);
    measure(found, hi, a, d, was_wr);
    chk("coll_hold_cycles", hi, 16);
    wait_rsp(got);
    chk("coll_rsp_error", rsp_error, 0);
    chk("coll_rsp_data", rsp_data, 32'h4040_0016);
    chk("coll_tcount", timeout_count, 1);
    wait_idle();

    // Write timeout.
    send(1'b1, 16'h0050, 32'h5555_AAAA, 0);
    measure(found, hi, a, d, was_wr);
    chk("wto_hold_cycles", hi, 16);
    wait_rsp(got);
    chk("wto_rsp_error", rsp_error, 1);
    chk("wto_rsp_data", rsp_data, 0);
    chk("wto_tcount", timeout_count, 2);
    wait_idle();

    // Asynchronous reset while a read request is outstanding.
    send(1'b0, 16'h0060, 32'h0, 0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (pcie_read_request) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_mid_found", found, 1);
    #2 reset_n = 1'b0;
    #1 chk("rst_mid_rd_req_async", pcie_read_request, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_tcount", timeout_count, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 250; i++) begin
      int r, dly;
      r = $urandom_range(0, 9);
      if (r == 0) dly = 0;
      else if (r == 1) dly = 16;
      else dly = $urandom_range(1, 6);
      send(1'($urandom_range(0, 1)), AW'(16'h0200 + $urandom_range(0, 7)), $urandom, dly);
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end
    wait_idle();
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
